fifo_burst_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It drains exactly `burst_len` words from the FIFO, whose read data is combinational and valid in the same cycle `read` is asserted while not empty. Words are delivered on a valid/ready output stream through a 2-entry registered skid buffer. The block sits between the FIFO's `read`/`empty`/`data_out` pins and any downstream consumer that can back-pressure.

---
 rtl/fifo_burst_reader_if.sv | 30 +++
 rtl/fifo_burst_reader.sv | 101 ++++++++++
 tb/tb_fifo_burst_reader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// FIFO-read and output-stream signals of the burst reader.
// master = the burst reader; slave = the FIFO plus the downstream consumer.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_read;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output fifo_read,
      input  fifo_empty,
      input  fifo_data,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  fifo_read,
      output fifo_empty,
      output fifo_data,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a combinational-read FIFO into a 2-entry skid buffer; 1-cycle pop-to-valid latency.
// Pops stop while the buffer holds 2 words, so out_ready never reaches fifo_read combinationally.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] burst_len,
   output logic                 busy,
   output logic                 done,
   fifo_burst_reader_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
   logic [1:0]            occ, occ_nxt;
   logic [DATA_WIDTH-1:0] head, head_nxt;
   logic [DATA_WIDTH-1:0] tail, tail_nxt;
   logic                  done_nxt;
   logic                  pop;
   logic                  xfer;

   assign pop           = (state == RUN) && !bus.fifo_empty && (occ < 2'd2) && (remaining != '0);
   assign xfer          = bus.out_valid && bus.out_ready;
   assign bus.fifo_read = pop;
   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_data  = head;
   assign busy          = (state != IDLE);

   always_comb begin
      occ_nxt  = occ;
      head_nxt = head;
      tail_nxt = tail;
      case ({pop, xfer})
         2'b10: begin
            occ_nxt = occ + 2'd1;
            if (occ == 2'd0) head_nxt = bus.fifo_data;
            else             tail_nxt = bus.fifo_data;
         end
         2'b01: begin
            occ_nxt  = occ - 2'd1;
            head_nxt = tail;
         end
         // Only reachable with occ==1: the head leaves as the new word arrives.
         2'b11: head_nxt = bus.fifo_data;
         default: ;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      done_nxt      = 1'b0;
      if (pop) remaining_nxt = remaining - LEN_WIDTH'(1);
      case (state)
         IDLE: begin
            if (start) begin
               if (burst_len != '0) begin
                  state_nxt     = RUN;
                  remaining_nxt = burst_len;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (pop && (remaining == LEN_WIDTH'(1))) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (occ_nxt == 2'd0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= '0;
         occ       <= 2'd0;
         head      <= '0;
         tail      <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         occ       <= occ_nxt;
         head      <= head_nxt;
         tail      <= tail_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO and burst model checked every cycle, plus directed literal checks.
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int LW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic          busy;
   logic          done;

   fifo_burst_reader_if #(.DATA_WIDTH(DW)) intf ();

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .burst_len (burst_len),
      .busy      (busy),
      .done      (done),
      .bus       (intf.master)
   );

   initial forever #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got[$];

   // Burst model: active flag, words still to pop, words popped but not yet delivered.
   bit            m_active;
   int            m_rem;
   logic [DW-1:0] m_buf[$];
   bit            m_done;

   int pop_cnt, done_cnt, run_len, run_max, bad_read;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   task automatic fifo_refresh();
      intf.fifo_empty = (fifo_q.size() == 0);
      intf.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      fifo_refresh();
   endtask

   task automatic flush();
      fifo_q.delete();
      fifo_refresh();
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_obs();
      got.delete();
      pop_cnt  = 0;
      done_cnt = 0;
      run_len  = 0;
      run_max  = 0;
      bad_read = 0;
   endtask

   task automatic start_burst(input logic [LW-1:0] len);
      start     = 1'b1;
      burst_len = len;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) tick();
      repeat (2) tick();
      chk(nm, done_cnt, target);
   endtask

   task automatic chk_seq(input string nm);
      chk({nm, " count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({nm, " word"}, got[i], exp_q[i]);
   endtask

   // Compare process: checks the DUT against the model mid-cycle, then advances the model one edge.
   initial begin
      bit pend_pop;
      bit e_read;
      forever begin
         @(negedge clock);
         pend_pop = 1'b0;
         if (!reset) begin
            m_active = 1'b0;
            m_rem    = 0;
            m_done   = 1'b0;
            m_buf.delete();
            run_len  = 0;
            chk("rst out_valid", intf.out_valid, 0);
            chk("rst fifo_read", intf.fifo_read, 0);
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst out_data", intf.out_data, 0);
         end else begin
            e_read = m_active && (m_rem > 0) && (fifo_q.size() > 0) && (m_buf.size() < 2);
            chk("fifo_read", intf.fifo_read, e_read);
            chk("out_valid", intf.out_valid, m_buf.size() != 0);
            if (m_buf.size() != 0) chk("out_data", intf.out_data, m_buf[0]);
            chk("busy", busy, m_active);
            chk("done", done, m_done);

            if (intf.fifo_read) begin
               pop_cnt++;
               run_len++;
               if (run_len > run_max) run_max = run_len;
               if (m_buf.size() == 2 || intf.fifo_empty) bad_read++;
               if (!intf.fifo_empty) pend_pop = 1'b1;
            end else begin
               run_len = 0;
            end
            if (done) done_cnt++;
            if (intf.out_valid && intf.out_ready) got.push_back(intf.out_data);

            m_done = 1'b0;
            if (m_buf.size() != 0 && intf.out_ready) void'(m_buf.pop_front());
            if (e_read) begin
               m_buf.push_back(fifo_q[0]);
               m_rem--;
            end
            if (!m_active) begin
               if (start) begin
                  if (burst_len == 0) m_done = 1'b1;
                  else begin
                     m_active = 1'b1;
                     m_rem    = int'(burst_len);
                  end
               end
            end else if (m_rem == 0 && m_buf.size() == 0) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
         @(posedge clock);
         #1;
         if (pend_pop) begin
            void'(fifo_q.pop_front());
            fifo_refresh();
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got %0d expected 0 remaining cycles", 1);
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] w;
      flush();
      intf.out_ready = 1'b0;
      clear_obs();
      #2;
      chk("reset out_valid", intf.out_valid, 0);
      chk("reset out_data", intf.out_data, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset fifo_read", intf.fifo_read, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // Straight 4-word burst, consumer always ready.
      clear_obs();
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (exp_q[i]) push(exp_q[i]);
      intf.out_ready = 1'b1;
      start_burst(8'd4);
      chk("t1 busy after start", busy, 1);
      chk("t1 read after start", intf.fifo_read, 1);
      wait_done("t1 done count", 1, 50);
      chk_seq("t1 order");
      chk("t1 pops", pop_cnt, 4);
      chk("t1 read run", run_max, 4);
      chk("t1 fifo drained", fifo_q.size(), 0);

      // Consumer stalled: buffer fills to two, head held.
      clear_obs();
      foreach (exp_q[i]) push(exp_q[i]);
      intf.out_ready = 1'b0;
      start_burst(8'd4);
      repeat (5) tick();
      chk("t2 pops while stalled", pop_cnt, 2);
      chk("t2 held data", intf.out_data, 8'h11);
      chk("t2 held valid", intf.out_valid, 1);
      chk("t2 no read at occ 2", intf.fifo_read, 0);
      intf.out_ready = 1'b1;
      wait_done("t2 done count", 1, 50);
      chk_seq("t2 order");

      // FIFO runs dry mid-burst.
      clear_obs();
      exp_q = '{8'h55, 8'h66, 8'h77};
      push(8'h55);
      start_burst(8'd3);
      repeat (6) tick();
      chk("t3 single pop", pop_cnt, 1);
      chk("t3 no early done", done_cnt, 0);
      chk("t3 busy waiting", busy, 1);
      push(8'h66);
      repeat (2) tick();
      push(8'h77);
      wait_done("t3 done count", 1, 50);
      chk_seq("t3 order");
      chk("t3 no read when empty", bad_read, 0);

      // Zero-length burst, then start ignored during RUN.
      clear_obs();
      start_burst(8'd0);
      chk("t4 zero done", done, 1);
      chk("t4 zero busy", busy, 0);
      chk("t4 zero read", intf.fifo_read, 0);
      tick();
      chk("t4 zero done one cycle", done, 0);
      clear_obs();
      exp_q = '{8'hA0, 8'hA1, 8'hA2};
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      start_burst(8'd3);
      tick();
      start     = 1'b1;
      burst_len = 8'd9;
      tick();
      start     = 1'b0;
      wait_done("t4 done count", 1, 50);
      chk_seq("t4 order");
      chk("t4 pops", pop_cnt, 3);
      chk("t4 fifo leftover", fifo_q.size(), 2);
      flush();

      // Reset mid-burst with a full buffer, then a clean 2-word burst.
      clear_obs();
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      intf.out_ready = 1'b0;
      start_burst(8'd4);
      repeat (3) tick();
      chk("t5 pops before reset", pop_cnt, 2);
      #2;
      reset = 1'b0;
      #1;
      chk("t5 async out_valid", intf.out_valid, 0);
      chk("t5 async out_data", intf.out_data, 0);
      chk("t5 async busy", busy, 0);
      chk("t5 async fifo_read", intf.fifo_read, 0);
      chk("t5 async done", done, 0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t5 no done after reset", done_cnt, 0);
      flush();
      clear_obs();
      exp_q = '{8'hB1, 8'hB2};
      push(8'hB1);
      push(8'hB2);
      intf.out_ready = 1'b1;
      start_burst(8'd2);
      wait_done("t5 done count", 1, 50);
      chk_seq("t5 order");

      // 255-word burst under random back-pressure, FIFO topped up every cycle.
      clear_obs();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         w = 8'($urandom);
         push(w);
         exp_q.push_back(w);
      end
      start_burst(8'd255);
      for (int i = 0; i < 3000 && done_cnt < 1; i++) begin
         if (fifo_q.size() < 3) begin
            w = 8'($urandom);
            push(w);
            if (exp_q.size() < 255) exp_q.push_back(w);
         end
         intf.out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      intf.out_ready = 1'b1;
      wait_done("t6 done count", 1, 10);
      chk_seq("t6 order");
      chk("t6 pops", pop_cnt, 255);
      chk("t6 no read at occ 2", bad_read, 0);
      flush();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
